// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : PC owner and fetch buffer feeding decode over valid/ready;
//                handles redirects, discards in-flight responses and flags
//                misaligned redirect targets.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instruction_address,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instruction,
    output logic [31:0] fetch_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] c_DEPTH = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic          r_pending;
    logic          r_fault;
    logic [31:0]   r_fault_pc;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_buf_pc    [FIFO_DEPTH];
    logic [31:0]   r_buf_instr [FIFO_DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [CW:0]   w_occ;

    assign fetch_valid = (r_count != '0);
    assign w_pop       = fetch_valid & fetch_ready;
    assign w_push      = r_pending & ~redirect_valid;
    // Occupancy after this edge's pop, counting the slot reserved by a pending response.
    assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_pending} - {{CW{1'b0}}, w_pop};
    assign w_issue     = ~redirect_valid & ~r_fault & (w_occ < c_DEPTH);

    assign instruction_address = r_pc;
    assign fetch_pc            = fetch_valid ? r_buf_pc[r_rd_ptr]    : 32'h0;
    assign fetch_instruction   = fetch_valid ? r_buf_instr[r_rd_ptr] : 32'h0;
    assign fetch_fault         = r_fault;
    assign fault_pc            = r_fault_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= 32'h0;
            r_pending  <= 1'b0;
            r_fault    <= 1'b0;
            r_fault_pc <= 32'h0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_valid) begin
            r_pending <= 1'b0;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            if (redirect_target[1:0] == 2'b00) begin
                r_pc    <= redirect_target;
                r_fault <= 1'b0;
            end else begin
                r_fault    <= 1'b1;
                r_fault_pc <= redirect_target;
            end
        end else begin
            if (w_issue) begin
                r_pending <= 1'b1;
                r_req_pc  <= r_pc;
                r_pc      <= r_pc + 32'd4;
            end else begin
                r_pending <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
        end
    end

    // Storage needs no reset: head outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]    <= r_req_pc;
            r_buf_instr[r_wr_ptr] <= instruction;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Self-checking bench for instruction_fetch_unit with a
//                queue-based reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int c_DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_ready;

    logic [31:0] addr0, instr0, fpc0, finstr0, fault_pc0;
    logic        fvalid0, ffault0;
    logic [31:0] addr1, instr1, fpc1, finstr1, fault_pc1;
    logic        fvalid1, ffault1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_rpc;
    logic        m_fault;
    logic [31:0] m_fpc;
    logic [31:0] m_q[$];

    instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(c_DEPTH)) dut0 (
        .clk(clk), .reset(reset),
        .instruction_address(addr0), .instruction(instr0),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fetch_valid(fvalid0), .fetch_ready(fetch_ready),
        .fetch_instruction(finstr0), .fetch_pc(fpc0),
        .fetch_fault(ffault0), .fault_pc(fault_pc0)
    );

    instruction_fetch_unit #(.RESET_PC(32'h100), .FIFO_DEPTH(c_DEPTH)) dut1 (
        .clk(clk), .reset(reset),
        .instruction_address(addr1), .instruction(instr1),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fetch_valid(fvalid1), .fetch_ready(fetch_ready),
        .fetch_instruction(finstr1), .fetch_pc(fpc1),
        .fetch_fault(ffault1), .fault_pc(fault_pc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // 1-cycle synchronous-read instruction memories
    always @(posedge clk) begin
        instr0 <= word(addr0);
        instr1 <= word(addr1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_pend  = 1'b0;
        m_rpc   = 32'h0;
        m_fault = 1'b0;
        m_fpc   = 32'h0;
        m_q.delete();
    endtask

    task automatic model_step(input logic rv, input logic [31:0] rt, input logic rdy);
        bit pop;
        bit issue;
        pop = (m_q.size() != 0) && rdy;
        if (rv) begin
            m_q.delete();
            m_pend = 1'b0;
            if (rt[1:0] == 2'b00) begin
                m_pc    = rt;
                m_fault = 1'b0;
            end else begin
                m_fault = 1'b1;
                m_fpc   = rt;
            end
        end else begin
            issue = !m_fault && (int'(m_q.size()) + int'(m_pend) - int'(pop) < c_DEPTH);
            if (pop) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(m_rpc);
            if (issue) begin
                m_pend = 1'b1;
                m_rpc  = m_pc;
                m_pc   = m_pc + 32'd4;
            end else begin
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] hpc;
        hpc = (m_q.size() != 0) ? m_q[0] : 32'h0;
        chk("valid", {31'b0, fvalid0}, {31'b0, m_q.size() != 0});
        chk("fetch_pc", fpc0, hpc);
        chk("fetch_instr", finstr0, (m_q.size() != 0) ? word(hpc) : 32'h0);
        chk("addr", addr0, m_pc);
        chk("fault", {31'b0, ffault0}, {31'b0, m_fault});
        chk("fault_pc", fault_pc0, m_fpc);
    endtask

    // Called at a falling edge: drive inputs, advance model, check after next rising edge.
    task automatic cycle(input logic rv, input logic [31:0] rt, input logic rdy);
        redirect_valid  = rv;
        redirect_target = rt;
        fetch_ready     = rdy;
        model_step(rv, rt, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic        rv;
        logic [31:0] rt;
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        fetch_ready     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        chk("rst_addr1", addr1, 32'h100);
        reset = 1'b1;

        // Streaming with decode always ready
        cycle(1'b0, 32'h0, 1'b1);
        chk("first_edge_valid", {31'b0, fvalid0}, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("first_pc", fpc0, 32'h0);
        chk("first_instr", finstr0, 32'h1000_0000);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

        // Back-pressure: restart stream, stall 6 cycles after first valid
        cycle(1'b1, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0);
        chk("stall_addr", addr0, 32'h8);
        chk("stall_head", fpc0, 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

        // Redirect mid-stream
        cycle(1'b1, 32'h40, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        chk("redir_gap", {31'b0, fvalid0}, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("redir_pc", fpc0, 32'h40);
        chk("redir_instr", finstr0, word(32'h40));

        // Misaligned redirect then recovery
        cycle(1'b1, 32'h42, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);
        chk("fault_pc_42", fault_pc0, 32'h42);
        chk("fault_nvalid", {31'b0, fvalid0}, 32'h0);
        cycle(1'b1, 32'h80, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        chk("recover_pc", fpc0, 32'h80);
        chk("recover_fault", {31'b0, ffault0}, 32'h0);

        // Redirect coincident with a pop
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h200, 1'b1);
        chk("redir_pop_empty", {31'b0, fvalid0}, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 9) == 0);
            rt = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 3) == 0) rt[1:0] = 2'($urandom_range(1, 3));
            cycle(rv, rt, $urandom_range(0, 9) < 7);
        end

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_addr1", addr1, 32'h100);
        chk("async_valid1", {31'b0, fvalid1}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        chk("restart_pc1", fpc1, 32'h100);
        chk("restart_instr1", finstr1, word(32'h100));
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
